// File: rtl/rotate_pipe_if.sv
// rtl/rotate_pipe_if.sv - valid/ready input and output channels of the pipelined rotator
interface rotate_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rotate_pipe.sv
// rtl/rotate_pipe.sv - pipelined barrel rotator/shifter, one amount bit resolved per stage
module rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  rotate_pipe_if.slave  bus,
  output logic          busy
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam int LAST  = AMT_W - 1;

  typedef enum logic [1:0] {
    MODE_ROTR = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROTL = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  logic [AMT_W-1:0]                r_valid;
  logic [AMT_W-1:0][WIDTH-1:0]     r_data;
  logic [AMT_W-1:0][TAG_W-1:0]     r_tag;
  // Remaining amount is kept right-aligned: bit 0 is always the next layer's bit.
  logic [LAST-1:0][AMT_W-2:0]      r_rem;
  logic [LAST-1:0][1:0]            r_mode;

  logic [AMT_W-1:0]                w_ld;
  logic [AMT_W-1:0]                w_src_valid;
  logic [AMT_W-1:0][WIDTH-1:0]     w_src_data;
  logic [AMT_W-1:0][TAG_W-1:0]     w_src_tag;
  logic [AMT_W-1:0][1:0]           w_src_mode;
  logic [AMT_W-1:0][AMT_W-1:0]     w_src_rem;
  logic [AMT_W-1:0]                w_apply;
  logic [AMT_W-1:0][WIDTH-1:0]     w_res;

  function automatic logic [WIDTH-1:0] layer_op(input logic [WIDTH-1:0] d,
                                                input logic [1:0] m,
                                                input int sh);
    case (m)
      MODE_ROTR: layer_op = (d >> sh) | (d << (WIDTH - sh));
      MODE_SHR:  layer_op = d >> sh;
      MODE_ROTL: layer_op = (d << sh) | (d >> (WIDTH - sh));
      default:   layer_op = d << sh;
    endcase
  endfunction

  // Load enables ripple back from out_ready so a full pipe can still stream.
  always_comb begin
    logic mv;
    logic ld_down;
    w_ld    = '0;
    ld_down = 1'b0;
    for (int k = LAST; k >= 0; k--) begin
      mv      = (k == LAST) ? (r_valid[LAST] && bus.out_ready) : ld_down;
      w_ld[k] = !r_valid[k] || mv;
      ld_down = w_ld[k];
    end
  end

  always_comb begin
    w_src_valid = '0;
    w_src_data  = '0;
    w_src_tag   = '0;
    w_src_mode  = '0;
    w_src_rem   = '0;
    w_apply     = '0;
    w_res       = '0;

    w_src_valid[0] = bus.in_valid;
    w_src_data[0]  = bus.in_data;
    w_src_tag[0]   = bus.in_tag;
    w_src_mode[0]  = bus.in_mode;
    w_src_rem[0]   = bus.in_amt;
    for (int k = 1; k < AMT_W; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_tag[k]   = r_tag[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_rem[k]   = {1'b0, r_rem[k-1]};
    end

    // Only bit 0 can be set by the last layer; upper bits were shifted out as zeros.
    for (int k = 0; k < AMT_W; k++) begin
      w_apply[k] = (k == LAST) ? (w_src_rem[k] != '0) : w_src_rem[k][0];
      w_res[k]   = w_apply[k] ? layer_op(w_src_data[k], w_src_mode[k], 1 << k)
                              : w_src_data[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
      r_tag   <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
    end else begin
      for (int k = 0; k < AMT_W; k++) begin
        if (w_ld[k]) begin
          r_valid[k] <= w_src_valid[k];
          r_data[k]  <= w_res[k];
          r_tag[k]   <= w_src_tag[k];
        end
      end
      for (int k = 0; k < LAST; k++) begin
        if (w_ld[k]) begin
          r_rem[k]  <= w_src_rem[k][AMT_W-1:1];
          r_mode[k] <= w_src_mode[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_valid[LAST];
  assign bus.out_data  = r_data[LAST];
  assign bus.out_tag   = r_tag[LAST];
  assign busy          = |r_valid;

endmodule

// File: tb/tb_rotate_pipe.sv
// tb/tb_rotate_pipe.sv - directed and randomised self-checking bench for rotate_pipe
module tb_rotate_pipe;
  localparam int W      = 32;
  localparam int TW     = 4;
  localparam int N_RAND = 4000;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [W-1:0]  d;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic busy8;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  rotate_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  rotate_pipe_if #(.WIDTH(8), .TAG_W(TW)) bus8 ();

  rotate_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy)
  );

  rotate_pipe #(.WIDTH(8), .TAG_W(TW)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [W-1:0] ref32(input logic [W-1:0] d, input logic [4:0] a,
                                         input logic [1:0] m);
    logic [2*W-1:0] dd;
    case (m)
      2'b00: begin dd = {d, d} >> a; ref32 = dd[W-1:0];   end
      2'b01: ref32 = d >> a;
      2'b10: begin dd = {d, d} << a; ref32 = dd[2*W-1:W]; end
      default: ref32 = d << a;
    endcase
  endfunction

  task automatic op32(input logic [W-1:0] d, input logic [4:0] a, input logic [1:0] m,
                      input logic [TW-1:0] t, output int lat,
                      output logic [W-1:0] od, output logic [TW-1:0] ot);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_mode  = m;
    bus.in_tag   = t;
    @(negedge clock);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    od = bus.out_data;
    ot = bus.out_tag;
    @(negedge clock);
  endtask

  initial begin
    int            lat;
    int            wait_n;
    int            next_tag;
    int            n_got;
    int            sent;
    int            rcvd;
    int            stale;
    int            tags[$];
    exp_t          q[$];
    exp_t          e;
    logic [W-1:0]  od;
    logic [TW-1:0] ot;
    logic          prev_stall;
    logic [W+TW-1:0] prev_out;
    logic [W-1:0]  b_d [4];
    logic [4:0]    b_a [4];
    logic [1:0]    b_m [4];
    logic [W-1:0]  b_x [4];

    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.in_amt  = '0; bus.in_mode  = '0;
    bus.in_tag    = '0;   bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_amt = '0; bus8.in_mode = '0;
    bus8.in_tag   = '0;   bus8.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst8_in_ready", bus8.in_ready, 1);

    op32(32'h0000_0080, 5'd7, 2'b00, 4'd3, lat, od, ot);
    chk("rotr1_latency", lat, 5);
    chk("rotr1_data", od, 32'h0000_0001);
    chk("rotr1_tag", ot, 3);
    op32(32'h0000_0001, 5'd7, 2'b00, 4'd5, lat, od, ot);
    chk("rotr2_data", od, 32'h0200_0000);
    chk("rotr2_tag", ot, 5);

    b_d = '{32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    b_a = '{5'd31, 5'd1, 5'd4, 5'd0};
    b_m = '{2'b01, 2'b10, 2'b11, 2'b10};
    b_x = '{32'h0000_0001, 32'h0000_0003, 32'hFFFF_FFF0, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b_d[i];
      bus.in_amt   = b_a[i];
      bus.in_mode  = b_m[i];
      bus.in_tag   = 4'(i + 8);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    wait_n = 0;
    while (!bus.out_valid && wait_n < 20) begin
      @(negedge clock);
      wait_n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("b2b_data%0d", i), bus.out_data, b_x[i]);
      chk($sformatf("b2b_tag%0d", i), bus.out_tag, 64'(i + 8));
      @(negedge clock);
    end
    chk("b2b_busy_after", busy, 0);

    bus.out_ready = 1'b0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    next_tag      = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (next_tag < 6);
      bus.in_tag   = next_tag[TW-1:0];
      bus.in_data  = 32'(next_tag);
      #1;
      if (bus.in_valid && bus.in_ready) next_tag++;
      @(negedge clock);
    end
    chk("bp_accepted", next_tag, 5);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_head_tag", bus.out_tag, 0);

    bus.out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 30 && n_got < 6; c++) begin
      bus.in_valid = (next_tag < 6);
      bus.in_tag   = next_tag[TW-1:0];
      bus.in_data  = 32'(next_tag);
      #1;
      if (bus.out_valid) begin
        tags.push_back(int'(bus.out_tag));
        n_got++;
      end
      if (bus.in_valid && bus.in_ready) next_tag++;
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    chk("bp_count", n_got, 6);
    for (int i = 0; i < tags.size(); i++) chk($sformatf("bp_order%0d", i), tags[i], i);
    chk("bp_no_dup_valid", bus.out_valid, 0);
    chk("bp_busy_drained", busy, 0);

    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < 60000 && rcvd < N_RAND; c++) begin
      if (prev_stall) chk("rand_stable", {bus.out_tag, bus.out_data}, prev_out);
      bus.in_valid  = (sent < N_RAND) && ($urandom_range(3) != 0);
      bus.in_data   = $urandom;
      bus.in_amt    = 5'($urandom_range(31));
      bus.in_mode   = 2'($urandom_range(3));
      bus.in_tag    = 4'($urandom_range(15));
      bus.out_ready = ($urandom_range(2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        chk("rand_underflow", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rand_result", {bus.out_tag, bus.out_data}, e);
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.d = ref32(bus.in_data, bus.in_amt, bus.in_mode);
        e.t = bus.in_tag;
        q.push_back(e);
        sent++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_tag, bus.out_data};
      @(negedge clock);
    end
    chk("rand_count", rcvd, N_RAND);
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA5A5_0000 + 32'(i);
      bus.in_tag   = 4'(i + 1);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      if (bus.out_valid) stale++;
      @(negedge clock);
    end
    chk("mid_no_stale", stale, 0);

    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'h81;
    bus8.in_amt   = 3'd1;
    bus8.in_mode  = 2'b00;
    bus8.in_tag   = 4'd9;
    @(negedge clock);
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("w8_latency", lat, 3);
    chk("w8_data", bus8.out_data, 8'hC0);
    chk("w8_tag", bus8.out_tag, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
